// File: rtl/compressor_seq_mult.sv
// Iterative unsigned N x N multiplier: one reused row of 4:2 compressors folds two partial products per cycle
// into a carry-save accumulator, then a single CPA cycle resolves it. Build option: LSB_TRUNC_EN (drop PP columns 0..3).

module exact_4to2_compressor (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic cin,
  output logic sum,
  output logic carry,
  output logic cout
);

  logic s1;

  // cout is independent of cin, so a row of these cells has no rippling carry path.
  assign s1    = x1 ^ x2 ^ x3;
  assign cout  = (x1 & x2) | (x1 & x3) | (x2 & x3);
  assign sum   = s1 ^ x4 ^ cin;
  assign carry = (s1 & x4) | (s1 & cin) | (x4 & cin);

endmodule

module compressor_seq_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int W     = 2 * N;
  localparam int ITERS = N / 2;
  localparam int CW    = $clog2(ITERS + 1);

  typedef enum logic [1:0] {IDLE, COMP, CPA, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  i_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [W-1:0]   acc_sum;
  logic [W-1:0]   acc_carry;
  logic [W-1:0]   product_reg;

  logic           accept;
  logic [CW:0]    sh0;
  logic [CW:0]    sh1;
  logic [1:0]     bpair;
  logic [W-1:0]   a_ext;
  logic [W-1:0]   pp0;
  logic [W-1:0]   pp1;
  logic [W-1:0]   row_sum;
  logic [W-1:0]   row_carry;
  logic [W-1:0]   row_cin;
  logic [W-1:0]   row_cout;
  logic           unused_msb;

  function automatic logic [W-1:0] pp_mask(input logic [W-1:0] v);
`ifdef LSB_TRUNC_EN
    return v & {{(W-4){1'b1}}, 4'b0000};
`else
    return v;
`endif
  endfunction

  assign accept = in_valid & in_ready;

  // Partial-product pair for iteration i: multiplier bits 2i and 2i+1.
  assign sh0   = {i_q, 1'b0};
  assign sh1   = {i_q, 1'b1};
  assign bpair = 2'(b_q >> sh0);
  assign a_ext = {{N{1'b0}}, a_q};
  assign pp0   = pp_mask((a_ext & {W{bpair[0]}}) << sh0);
  assign pp1   = pp_mask((a_ext & {W{bpair[1]}}) << sh1);

  assign row_cin = {row_cout[W-2:0], 1'b0};

  for (genvar j = 0; j < W; j++) begin : g_row
    exact_4to2_compressor u_cell (
      .x1    (pp0[j]),
      .x2    (pp1[j]),
      .x3    (acc_sum[j]),
      .x4    (acc_carry[j]),
      .cin   (row_cin[j]),
      .sum   (row_sum[j]),
      .carry (row_carry[j]),
      .cout  (row_cout[j])
    );
  end

  // Weight 2^W is beyond the product width.
  assign unused_msb = row_cout[W-1] ^ row_carry[W-1];

  // Operand capture: held for the whole operation, so later input changes do not matter.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      i_q         <= '0;
      acc_sum     <= '0;
      acc_carry   <= '0;
      product_reg <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= COMP;
            i_q       <= '0;
            acc_sum   <= '0;
            acc_carry <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        COMP: begin
          // After the last fold the counter sits at ITERS for one cycle, giving N/2+2 total latency.
          if (i_q == CW'(ITERS)) begin
            state <= CPA;
          end else begin
            acc_sum   <= row_sum;
            acc_carry <= {row_carry[W-2:0], 1'b0};
            i_q       <= i_q + CW'(1);
          end
        end
        CPA: begin
          product_reg <= acc_sum + acc_carry;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            i_q       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_compressor_seq_mult.sv
// Scoreboard bench for compressor_seq_mult (N=8): directed vectors, decoupled monitor.

module tb_compressor_seq_mult;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

`ifdef LSB_TRUNC_EN
  localparam bit TRUNC = 1'b1;
`else
  localparam bit TRUNC = 1'b0;
`endif

  typedef struct {
    logic [15:0] prod;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_hs = -1;
  int          ov_len = 0;
  logic        prev_ov = 1'b0;
  logic [15:0] last_prod = '0;
  int          acc1;
  int          acc2;

  compressor_seq_mult #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic send(input logic [7:0] va, input logic [7:0] vb,
                      input logic [15:0] ex, input logic [15:0] tr, output int acc_edge);
    int n;
    n = 0;
    @(negedge clk);
    a = va;
    b = vb;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 100), 1);
    acc_edge = cyc + 1;
    exp_q.push_back('{prod: (TRUNC ? tr : ex), acc: acc_edge});
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_wait", 32'(n < 100), 1);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_product", 32'(product), 0);
      exp_q.delete();
      prev_ov = 1'b0;
      last_prod = '0;
      ov_len = 0;
    end else begin
      check("busy_vs_in_ready", 32'(busy), 32'(!in_ready));
      if (out_valid && !prev_ov) begin
        ov_len = 1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: product %0d, want no output (cycle %0d)", product, cyc);
        end else begin
          e = exp_q.pop_front();
          check("product", 32'(product), 32'(e.prod));
          check("latency", 32'(cyc - e.acc), 6);
          last_prod = e.prod;
        end
      end else if (out_valid) begin
        ov_len++;
        check("hold_product", 32'(product), 32'(last_prod));
      end else begin
        check("idle_product", 32'(product), 32'(last_prod));
      end
      if (out_valid) check("done_in_ready", 32'(in_ready), 0);
      if (prev_ov && !out_valid) last_hs = cyc;
      prev_ov = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Full-scale operands
    send(8'd255, 8'd255, 16'd65025, 16'd64976, acc1);
    wait_done();

    // Zero product, then back-to-back request held from the DONE cycle
    send(8'd0, 8'd173, 16'd0, 16'd0, acc1);
    send(8'd13, 8'd11, 16'd143, 16'd112, acc2);
    check("turnaround_edge", 32'(acc2), 32'(last_hs + 1));
    wait_done();

    // Stall in DONE while inputs toggle
    out_ready = 1'b0;
    send(8'd255, 8'd255, 16'd65025, 16'd64976, acc1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("out_valid_wait", 32'(n < 50), 1);
    end
    repeat (5) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      in_valid = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();
    check("stall_length", 32'(ov_len), 7);

    // Reset in the third COMP cycle discards the operation
    send(8'd200, 8'd100, 16'd20000, 16'd0, acc1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send(8'd3, 8'd5, 16'd15, 16'd0, acc1);
    wait_done();

    // Assorted patterns
    send(8'd15, 8'd15, 16'd225, 16'd176, acc1);
    send(8'd1, 8'd255, 16'd255, 16'd240, acc1);
    send(8'd128, 8'd2, 16'd256, 16'd256, acc1);
    send(8'd1, 8'd1, 16'd1, 16'd0, acc1);
    wait_done();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
